// File: rtl/fsm_qual_state_bank_if.sv
// Handshake-free control bundle for the qualified two-state FSM bank.
// master drives controls and raw inputs, slave returns state and edge pulses.
interface fsm_qual_state_bank_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic [CH-1:0]    in;
    logic [CH-1:0]    mode;
    logic [CNT_W-1:0] hold_cfg;
    logic [CH-1:0]    state_out;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;

    modport master (
        output en, in, mode, hold_cfg,
        input  state_out, rise, fall
    );

    modport slave (
        input  en, in, mode, hold_cfg,
        output state_out, rise, fall
    );
endinterface

// File: rtl/fsm_qual_state_bank.sv
// Bank of CH glitch-filtered S0/S1 FSMs with level-follow or toggle mode.
// Each input must hold for hold_cfg+1 enabled edges before it is accepted.
module fsm_qual_state_bank #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fsm_qual_state_bank_if.slave bus
);
    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } st_e;

    st_e              st_q  [CH];
    st_e              st_d  [CH];
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic [CH-1:0]    q_q;
    logic [CH-1:0]    q_d;
    logic [CH-1:0]    rise_q;
    logic [CH-1:0]    rise_d;
    logic [CH-1:0]    fall_q;
    logic [CH-1:0]    fall_d;
    logic [CH-1:0]    diff;
    logic [CH-1:0]    qual;
    logic [CH-1:0]    st_vec;

    // >= rather than == so a lowered hold_cfg qualifies immediately
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            diff[i] = bus.in[i] ^ q_q[i];
            qual[i] = diff[i] && (cnt_q[i] >= bus.hold_cfg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= S0;
                cnt_q[i] <= '0;
            end
        end else begin
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < CH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        q_d    = q_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < CH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
        end
        if (bus.en) begin
            for (int i = 0; i < CH; i++) begin
                unique case (1'b1)
                    !diff[i]: cnt_d[i] = '0;
                    qual[i]: begin
                        q_d[i]   = bus.in[i];
                        cnt_d[i] = '0;
                    end
                    default: cnt_d[i] = cnt_q[i] + 1'b1;
                endcase
                // toggle mode only reacts to rising qualifications
                if (!bus.mode[i]) begin
                    st_d[i] = st_e'(q_d[i]);
                end else if (qual[i] && bus.in[i]) begin
                    st_d[i] = (st_q[i] == S1) ? S0 : S1;
                end
                rise_d[i] = (st_q[i] == S0) && (st_d[i] == S1);
                fall_d[i] = (st_q[i] == S1) && (st_d[i] == S0);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            st_vec[i] = st_q[i];
        end
    end

    assign bus.state_out = st_vec;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
endmodule

// File: tb/tb_fsm_qual_state_bank.sv
// Self-checking bench: directed scenarios plus random stimulus
// compared every cycle against a behavioural per-channel model.
module tb_fsm_qual_state_bank;
    localparam int CH    = 4;
    localparam int CNT_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    fsm_qual_state_bank_if #(.CH(CH), .CNT_W(CNT_W)) bus ();

    fsm_qual_state_bank #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    bit mq    [CH];
    int mcnt  [CH];
    bit mst   [CH];
    bit mrise [CH];
    bit mfall [CH];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mq[i] = 0; mcnt[i] = 0; mst[i] = 0;
            mrise[i] = 0; mfall[i] = 0;
        end
    endtask

    task automatic model_edge();
        int h;
        bit old, din, qualify;
        h = int'(bus.hold_cfg);
        for (int i = 0; i < CH; i++) begin
            mrise[i] = 0;
            mfall[i] = 0;
            if (bus.en) begin
                din = bus.in[i];
                old = mst[i];
                qualify = (din != mq[i]) && (mcnt[i] >= h);
                if (din == mq[i]) mcnt[i] = 0;
                else if (qualify) begin
                    mq[i] = din;
                    mcnt[i] = 0;
                end else mcnt[i] = mcnt[i] + 1;
                if (!bus.mode[i]) mst[i] = mq[i];
                else if (qualify && din) mst[i] = !mst[i];
                mrise[i] = !old && mst[i];
                mfall[i] = old && !mst[i];
            end
        end
    endtask

    task automatic cmp_all();
        logic [CH-1:0] es, er, ef;
        for (int i = 0; i < CH; i++) begin
            es[i] = mst[i]; er[i] = mrise[i]; ef[i] = mfall[i];
        end
        check("state_out", 32'(bus.state_out), 32'(es));
        check("rise", 32'(bus.rise), 32'(er));
        check("fall", 32'(bus.fall), 32'(ef));
        check("rise_and_fall", 32'(bus.rise & bus.fall), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cmp_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // asserts reset mid-cycle and checks outputs clear without a clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_state", 32'(bus.state_out), 32'd0);
        check("rst_rise", 32'(bus.rise), 32'd0);
        check("rst_fall", 32'(bus.fall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int nr, nf;

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.in   = '0;
        bus.mode = '0;
        bus.hold_cfg = '0;
        model_reset();
        #3;
        do_reset();

        // 1: H=0 single-edge latency
        ticks(3);
        bus.in[0] = 1'b1;
        tick();
        check("t1_st", 32'(bus.state_out[0]), 32'd1);
        check("t1_rise", 32'(bus.rise[0]), 32'd1);
        tick();
        check("t1_rise_off", 32'(bus.rise[0]), 32'd0);
        bus.in[0] = 1'b0;
        tick();
        check("t1_fall", 32'(bus.fall[0]), 32'd1);
        check("t1_st0", 32'(bus.state_out[0]), 32'd0);

        // 2: H=3 glitch rejection then qualify
        bus.hold_cfg = 8'd3;
        ticks(2);
        bus.in[1] = 1'b1;
        ticks(3);
        bus.in[1] = 1'b0;
        ticks(3);
        check("t2_glitch", 32'(bus.state_out[1]), 32'd0);
        bus.in[1] = 1'b1;
        ticks(3);
        check("t2_early", 32'(bus.state_out[1]), 32'd0);
        tick();
        check("t2_st", 32'(bus.state_out[1]), 32'd1);
        check("t2_rise", 32'(bus.rise[1]), 32'd1);

        // 3: H=2 toggle mode, two pulses
        do_reset();
        bus.in = '0;
        bus.hold_cfg = 8'd2;
        bus.mode[2] = 1'b1;
        nr = 0; nf = 0;
        for (int p = 0; p < 4; p++) begin
            bus.in[2] = (p % 2 == 0);
            for (int k = 0; k < 5; k++) begin
                tick();
                nr += int'(bus.rise[2]);
                nf += int'(bus.fall[2]);
            end
            if (p == 0) check("t3_st1", 32'(bus.state_out[2]), 32'd1);
        end
        check("t3_nrise", 32'(nr), 32'd1);
        check("t3_nfall", 32'(nf), 32'd1);
        check("t3_st", 32'(bus.state_out[2]), 32'd0);
        bus.mode[2] = 1'b0;

        // 4: H=4 with en freeze mid-count
        do_reset();
        bus.hold_cfg = 8'd4;
        bus.in[3] = 1'b1;
        ticks(2);
        bus.en = 1'b0;
        ticks(10);
        check("t4_frozen", 32'(bus.state_out[3]), 32'd0);
        bus.en = 1'b1;
        ticks(2);
        check("t4_early", 32'(bus.state_out[3]), 32'd0);
        tick();
        check("t4_st", 32'(bus.state_out[3]), 32'd1);
        bus.in = '0;

        // 5: lowered hold_cfg mid-count, then toggle->level realign
        do_reset();
        bus.hold_cfg = 8'd8;
        bus.mode[0] = 1'b1;
        bus.in[0] = 1'b1;
        ticks(9);
        check("t5_st1", 32'(bus.state_out[0]), 32'd1);
        bus.in[0] = 1'b0;
        ticks(5);
        bus.hold_cfg = 8'd2;
        tick();
        check("t5_hold", 32'(bus.state_out[0]), 32'd1);
        bus.mode[0] = 1'b0;
        tick();
        check("t5_fall", 32'(bus.fall[0]), 32'd1);
        check("t5_st0", 32'(bus.state_out[0]), 32'd0);

        // 6: reset mid-count and in S1 on all channels
        do_reset();
        bus.mode = '0;
        bus.hold_cfg = 8'd3;
        bus.in = '1;
        ticks(4);
        check("t6_all1", 32'(bus.state_out), 32'hf);
        bus.in = '0;
        ticks(2);
        do_reset();
        bus.in = '1;
        ticks(3);
        check("t6_norun", 32'(bus.state_out), 32'd0);
        tick();
        check("t6_run", 32'(bus.state_out), 32'hf);

        // random phase
        for (int c = 0; c < 3000; c++) begin
            bus.en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 3) == 0) bus.in[i] = ~bus.in[i];
                if ($urandom_range(0, 39) == 0) bus.mode[i] = ~bus.mode[i];
            end
            if ($urandom_range(0, 49) == 0)
                bus.hold_cfg = CNT_W'($urandom_range(0, 5));
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
